// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge port between mem_stage and the data memory.
// The master side (mem_stage) raises mem_req_o with a stable address, write
// enable and store data, and holds them until the memory answers with
// mem_ack_i (plus mem_rdata_i for loads).
interface mem_stage_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        input  mem_ack_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        output mem_ack_i,
        output mem_rdata_i
    );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: takes the EX result and either forwards ALU results to
// writeback (1-cycle latency) or performs a word load/store over a req/ack
// data-memory port, stalling the front end while the access is in flight.
// An access with no acknowledge within TIMEOUT request cycles is abandoned
// and reported on err_o.
//
// Optional feature: define MISALIGN_TRAP_EN to reject lw/sw whose address has
// non-zero low bits (misalign_o pulse, no request). Without it, misaligned
// addresses are silently rounded down to the word boundary.
module mem_stage #(
    parameter int TIMEOUT = 16          // request cycles before giving up (2..255)
) (
    input  logic        clk,
    input  logic        rst,

    // EX-stage result
    input  logic        valid_i,
    input  logic [4:0]  ALUop_i,
    input  logic [31:0] ALUOut_i,
    input  logic [31:0] StoreData_i,
    input  logic [4:0]  WriteReg_i,

    // Front-end hold
    output logic        stall_o,

    // Register-file write port
    output logic        wb_valid_o,
    output logic [31:0] wb_data_o,
    output logic [4:0]  wb_reg_o,

    // Status pulses
    output logic        err_o,
    output logic        misalign_o,

    // Data-memory port
    mem_stage_if.master mem
);

    localparam logic [4:0] OP_LW    = 5'b10100;
    localparam logic [4:0] OP_SW    = 5'b10101;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    logic [7:0]  cnt_reg;

    // Access latches, driven straight onto the memory port so they stay
    // stable for the whole request.
    logic        mem_req_reg;
    logic        we_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [4:0]  dst_reg;

    // Registered writeback / status outputs
    logic        wb_valid_reg;
    logic [31:0] wb_data_reg;
    logic [4:0]  wb_reg_reg;
    logic        err_reg;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_reg;
`endif

    // Decode of the incoming EX result
    logic        is_mem_op;
    logic        can_accept;
    logic        misaligned;
    logic        start_access;

    assign is_mem_op  = valid_i && ((ALUop_i == OP_LW) || (ALUop_i == OP_SW));
    // DONE behaves like IDLE for new work so loads/stores can issue back-to-back.
    assign can_accept = (state_reg == IDLE) || (state_reg == DONE);

`ifdef MISALIGN_TRAP_EN
    assign misaligned = (ALUOut_i[1:0] != 2'b00);
`else
    // Low address bits are dropped when the word address is formed.
    logic [1:0] unused_addr_lsb;
    assign unused_addr_lsb = ALUOut_i[1:0];
    assign misaligned      = 1'b0;
`endif

    assign start_access = can_accept && is_mem_op && !misaligned;

    // Stall is combinational on accept so the front end holds the same cycle.
    assign stall_o = !rst && ((state_reg == REQ) || start_access);

    assign wb_valid_o = wb_valid_reg;
    assign wb_data_o  = wb_data_reg;
    assign wb_reg_o   = wb_reg_reg;
    assign err_o      = err_reg;
`ifdef MISALIGN_TRAP_EN
    assign misalign_o = misalign_reg;
`else
    assign misalign_o = 1'b0;
`endif

    assign mem.mem_req_o   = mem_req_reg;
    assign mem.mem_we_o    = we_reg;
    assign mem.mem_addr_o  = addr_reg;
    assign mem.mem_wdata_o = wdata_reg;

    // Main FSM: accept EX results, run the memory handshake, produce writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= 8'd0;
            mem_req_reg  <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= 32'd0;
            wdata_reg    <= 32'd0;
            dst_reg      <= 5'd0;
            wb_valid_reg <= 1'b0;
            wb_data_reg  <= 32'd0;
            wb_reg_reg   <= 5'd0;
            err_reg      <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_reg <= 1'b0;
`endif
        end else begin
            // Pulse outputs default low every cycle.
            wb_valid_reg <= 1'b0;
            err_reg      <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE, DONE: begin
                    state_reg <= IDLE;
                    if (valid_i) begin
                        if (is_mem_op) begin
                            if (misaligned) begin
`ifdef MISALIGN_TRAP_EN
                                misalign_reg <= 1'b1;
`endif
                            end else begin
                                addr_reg    <= {ALUOut_i[31:2], 2'b00};
                                wdata_reg   <= StoreData_i;
                                dst_reg     <= WriteReg_i;
                                we_reg      <= (ALUop_i == OP_SW);
                                mem_req_reg <= 1'b1;
                                cnt_reg     <= 8'd0;
                                state_reg   <= REQ;
                            end
                        end else begin
                            // ALU result goes straight to writeback; x0 is never written.
                            wb_valid_reg <= (WriteReg_i != 5'd0);
                            wb_data_reg  <= ALUOut_i;
                            wb_reg_reg   <= WriteReg_i;
                        end
                    end
                end

                REQ: begin
                    if (mem.mem_ack_i) begin
                        mem_req_reg <= 1'b0;
                        cnt_reg     <= 8'd0;
                        state_reg   <= DONE;
                        if (!we_reg) begin
                            wb_valid_reg <= (dst_reg != 5'd0);
                            wb_data_reg  <= mem.mem_rdata_i;
                            wb_reg_reg   <= dst_reg;
                        end
                    end else if (cnt_reg == CNT_LAST) begin
                        // Give up: drop the request, flag it, no writeback.
                        mem_req_reg <= 1'b0;
                        cnt_reg     <= 8'd0;
                        err_reg     <= 1'b1;
                        state_reg   <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end

                default: begin
                    state_reg   <= IDLE;
                    mem_req_reg <= 1'b0;
                    cnt_reg     <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage. Inputs are driven 1 ns after the rising
// edge, outputs are checked on the falling edge. The memory side is played by
// the bench through the slave view of mem_stage_if.
module tb_mem_stage;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_LW  = 5'b10100;
    localparam logic [4:0] OP_SW  = 5'b10101;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [4:0]  aluop;
    logic [31:0] aluout;
    logic [31:0] sdata;
    logic [4:0]  wreg;
    logic        stall;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_reg;
    logic        err;
    logic        misalign;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage_if mif ();

    mem_stage #(.TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid),
        .ALUop_i     (aluop),
        .ALUOut_i    (aluout),
        .StoreData_i (sdata),
        .WriteReg_i  (wreg),
        .stall_o     (stall),
        .wb_valid_o  (wb_valid),
        .wb_data_o   (wb_data),
        .wb_reg_o    (wb_reg),
        .err_o       (err),
        .misalign_o  (misalign),
        .mem         (mif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] r);
        valid  = 1'b1;
        aluop  = op;
        aluout = a;
        sdata  = d;
        wreg   = r;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        valid = 1'b0; aluop = '0; aluout = '0; sdata = '0; wreg = '0;
        mif.mem_ack_i = 1'b0; mif.mem_rdata_i = '0;
        tick;
        tick;
        @(negedge clk);
        n_checks++;
        if ({stall, wb_valid, err, misalign, mif.mem_req_o, mif.mem_we_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got stall/wbv/err/mis/req/we=%b required 000000",
                     {stall, wb_valid, err, misalign, mif.mem_req_o, mif.mem_we_o});
        end
        n_checks++;
        if ({wb_data, wb_reg, mif.mem_addr_o, mif.mem_wdata_o} !== 101'b0) begin
            n_fail++;
            $display("FAIL reset_data: got wb_data=%h wb_reg=%0d addr=%h wdata=%h required all 0",
                     wb_data, wb_reg, mif.mem_addr_o, mif.mem_wdata_o);
        end
        tick;
        rst = 1'b0;
        tick;
        $display("txn reset: outputs cleared");
    endtask

    task automatic test_alu;
        issue(OP_ADD, 32'h0000_0005, 32'h0, 5'd3);
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_stall: got %b required 0", stall);
        end
        tick;
        valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({wb_valid, wb_data, wb_reg, stall} !== {1'b1, 32'h5, 5'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL alu_wb: got wbv=%b data=%h reg=%0d stall=%b required 1/00000005/3/0",
                     wb_valid, wb_data, wb_reg, stall);
        end
        tick;
        @(negedge clk);
        n_checks++;
        if (wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_pulse: got wb_valid=%b required 0", wb_valid);
        end
        tick;
        $display("txn alu: x3 <= %h", 32'h5);
    endtask

    task automatic test_lw_delayed;
        issue(OP_LW, 32'h0000_0100, 32'h0, 5'd7);
        @(negedge clk);
        n_checks++;
        if ({stall, mif.mem_req_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL lw_accept: got stall/req=%b required 10", {stall, mif.mem_req_o});
        end
        tick;
        valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mif.mem_ack_i   = (i == 2);
            mif.mem_rdata_i = (i == 2) ? 32'hDEAD_BEEF : 32'h0;
            @(negedge clk);
            n_checks++;
            if ({mif.mem_req_o, mif.mem_we_o, mif.mem_addr_o, stall} !== {1'b1, 1'b0, 32'h100, 1'b1}) begin
                n_fail++;
                $display("FAIL lw_req%0d: got req=%b we=%b addr=%h stall=%b required 1/0/00000100/1",
                         i, mif.mem_req_o, mif.mem_we_o, mif.mem_addr_o, stall);
            end
            tick;
        end
        mif.mem_ack_i = 1'b0;
        mif.mem_rdata_i = '0;
        @(negedge clk);
        n_checks++;
        if ({wb_valid, wb_data, wb_reg, mif.mem_req_o, stall} !== {1'b1, 32'hDEAD_BEEF, 5'd7, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL lw_wb: got wbv=%b data=%h reg=%0d req=%b stall=%b required 1/deadbeef/7/0/0",
                     wb_valid, wb_data, wb_reg, mif.mem_req_o, stall);
        end
        tick;
        $display("txn lw: x7 <= mem[%h] = %h", 32'h100, 32'hDEAD_BEEF);
    endtask

    task automatic test_sw_same_cycle;
        issue(OP_SW, 32'h0000_0020, 32'h0000_1234, 5'd0);
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL sw_accept: got stall=%b required 1", stall);
        end
        tick;
        valid = 1'b0;
        mif.mem_ack_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({mif.mem_req_o, mif.mem_we_o, mif.mem_addr_o, mif.mem_wdata_o, stall}
                !== {1'b1, 1'b1, 32'h20, 32'h1234, 1'b1}) begin
            n_fail++;
            $display("FAIL sw_req: got req=%b we=%b addr=%h wdata=%h stall=%b required 1/1/00000020/00001234/1",
                     mif.mem_req_o, mif.mem_we_o, mif.mem_addr_o, mif.mem_wdata_o, stall);
        end
        tick;
        mif.mem_ack_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mif.mem_req_o, wb_valid, stall} !== 3'b000) begin
            n_fail++;
            $display("FAIL sw_done: got req/wbv/stall=%b required 000", {mif.mem_req_o, wb_valid, stall});
        end
        tick;
        $display("txn sw: mem[%h] <= %h", 32'h20, 32'h1234);
    endtask

    task automatic test_timeout;
        int req_cycles = 0;
        bit ended = 1'b0;
        issue(OP_LW, 32'h0000_0040, 32'h0, 5'd9);
        tick;
        valid = 1'b0;
        for (int i = 0; i < 40 && !ended; i++) begin
            @(negedge clk);
            if (mif.mem_req_o === 1'b1) begin
                req_cycles++;
            end else begin
                ended = 1'b1;
                n_checks++;
                if ({err, wb_valid, stall} !== 3'b100) begin
                    n_fail++;
                    $display("FAIL timeout_err: got err/wbv/stall=%b required 100", {err, wb_valid, stall});
                end
            end
            tick;
        end
        n_checks++;
        if (!ended || req_cycles != 16) begin
            n_fail++;
            $display("FAIL timeout_len: got %0d req cycles (ended=%0b) required 16", req_cycles, ended);
        end
        @(negedge clk);
        n_checks++;
        if ({err, wb_valid, stall, mif.mem_req_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL timeout_after: got err/wbv/stall/req=%b required 0000",
                     {err, wb_valid, stall, mif.mem_req_o});
        end
        tick;
        $display("txn lw timeout: %0d request cycles then err", req_cycles);
    endtask

    task automatic test_reset_mid;
        issue(OP_LW, 32'h0000_0080, 32'h0, 5'd4);
        tick;
        valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mif.mem_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_req: got req=%b required 1", mif.mem_req_o);
        end
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({stall, wb_valid, err, misalign, mif.mem_req_o, mif.mem_we_o, wb_data, mif.mem_addr_o} !== 70'b0) begin
            n_fail++;
            $display("FAIL rstmid_clear: got stall=%b wbv=%b err=%b req=%b addr=%h wb_data=%h required all 0",
                     stall, wb_valid, err, mif.mem_req_o, mif.mem_addr_o, wb_data);
        end
        tick;
        @(negedge clk);
        n_checks++;
        if ({wb_valid, mif.mem_req_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL rstmid_nowb: got wbv/req=%b required 00", {wb_valid, mif.mem_req_o});
        end
        tick;
        // Load to x0: the access runs but nothing is written back.
        issue(OP_LW, 32'h0000_0084, 32'h0, 5'd0);
        tick;
        valid = 1'b0;
        mif.mem_ack_i = 1'b1;
        mif.mem_rdata_i = 32'h0000_0055;
        @(negedge clk);
        n_checks++;
        if ({mif.mem_req_o, mif.mem_addr_o} !== {1'b1, 32'h84}) begin
            n_fail++;
            $display("FAIL x0_req: got req=%b addr=%h required 1/00000084", mif.mem_req_o, mif.mem_addr_o);
        end
        tick;
        mif.mem_ack_i = 1'b0;
        mif.mem_rdata_i = '0;
        @(negedge clk);
        n_checks++;
        if ({wb_valid, mif.mem_req_o, stall} !== 3'b000) begin
            n_fail++;
            $display("FAIL x0_wb: got wbv/req/stall=%b required 000", {wb_valid, mif.mem_req_o, stall});
        end
        tick;
        $display("txn reset mid-access, then lw x0 <= mem[%h] (discarded)", 32'h84);
    endtask

    task automatic test_back_to_back;
        issue(OP_LW, 32'h0000_0008, 32'h0, 5'd5);
        tick;
        valid = 1'b0;
        mif.mem_ack_i = 1'b1;
        mif.mem_rdata_i = 32'h0000_00AA;
        @(negedge clk);
        tick;
        mif.mem_ack_i = 1'b0;
        mif.mem_rdata_i = '0;
        // DONE cycle: issue an ALU op right away.
        issue(OP_ADD, 32'h0000_0077, 32'h0, 5'd6);
        @(negedge clk);
        n_checks++;
        if ({wb_valid, wb_data, wb_reg, stall} !== {1'b1, 32'hAA, 5'd5, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_lw: got wbv=%b data=%h reg=%0d stall=%b required 1/000000aa/5/0",
                     wb_valid, wb_data, wb_reg, stall);
        end
        tick;
        valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({wb_valid, wb_data, wb_reg} !== {1'b1, 32'h77, 5'd6}) begin
            n_fail++;
            $display("FAIL b2b_alu: got wbv=%b data=%h reg=%0d required 1/00000077/6",
                     wb_valid, wb_data, wb_reg);
        end
        tick;
        $display("txn back-to-back: x5 <= %h, x6 <= %h", 32'hAA, 32'h77);
    endtask

    task automatic test_ignored;
        valid = 1'b0;
        mif.mem_ack_i = 1'b1;
        mif.mem_rdata_i = 32'h0000_0099;
        @(negedge clk);
        n_checks++;
        if ({mif.mem_req_o, stall} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_ack_req: got req/stall=%b required 00", {mif.mem_req_o, stall});
        end
        tick;
        mif.mem_ack_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ack_wb: got wbv=%b required 0", wb_valid);
        end
        issue(OP_LW, 32'h0000_000C, 32'h0, 5'd11);
        tick;
        // valid_i in REQ must be ignored.
        issue(OP_ADD, 32'h0000_0123, 32'h0, 5'd10);
        mif.mem_ack_i = 1'b1;
        mif.mem_rdata_i = 32'h0000_0044;
        @(negedge clk);
        n_checks++;
        if ({mif.mem_req_o, stall} !== 2'b11) begin
            n_fail++;
            $display("FAIL req_valid_req: got req/stall=%b required 11", {mif.mem_req_o, stall});
        end
        tick;
        valid = 1'b0;
        mif.mem_ack_i = 1'b0;
        mif.mem_rdata_i = '0;
        @(negedge clk);
        n_checks++;
        if ({wb_valid, wb_data, wb_reg} !== {1'b1, 32'h44, 5'd11}) begin
            n_fail++;
            $display("FAIL req_valid_lw: got wbv=%b data=%h reg=%0d required 1/00000044/11",
                     wb_valid, wb_data, wb_reg);
        end
        tick;
        @(negedge clk);
        n_checks++;
        if (wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL req_valid_drop: got wbv=%b required 0", wb_valid);
        end
        // ALU op to x0 produces no writeback.
        issue(OP_ADD, 32'h0000_0009, 32'h0, 5'd0);
        tick;
        valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_x0: got wbv=%b required 0", wb_valid);
        end
        tick;
        $display("txn ignored inputs: ack in IDLE, valid in REQ, ALU to x0");
    endtask

    task automatic test_misalign;
        issue(OP_LW, 32'h0000_0102, 32'h0, 5'd12);
`ifdef MISALIGN_TRAP_EN
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL mis_stall: got stall=%b required 0", stall);
        end
        tick;
        valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({misalign, mif.mem_req_o, wb_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL mis_pulse: got mis/req/wbv=%b required 100", {misalign, mif.mem_req_o, wb_valid});
        end
        tick;
        @(negedge clk);
        n_checks++;
        if ({misalign, mif.mem_req_o, stall} !== 3'b000) begin
            n_fail++;
            $display("FAIL mis_after: got mis/req/stall=%b required 000", {misalign, mif.mem_req_o, stall});
        end
        tick;
        $display("txn lw misaligned %h: trapped", 32'h102);
`else
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL mis_stall: got stall=%b required 1", stall);
        end
        tick;
        valid = 1'b0;
        mif.mem_ack_i = 1'b1;
        mif.mem_rdata_i = 32'h0000_0066;
        @(negedge clk);
        n_checks++;
        if ({mif.mem_req_o, mif.mem_addr_o, misalign} !== {1'b1, 32'h100, 1'b0}) begin
            n_fail++;
            $display("FAIL mis_addr: got req=%b addr=%h mis=%b required 1/00000100/0",
                     mif.mem_req_o, mif.mem_addr_o, misalign);
        end
        tick;
        mif.mem_ack_i = 1'b0;
        mif.mem_rdata_i = '0;
        @(negedge clk);
        n_checks++;
        if ({wb_valid, wb_data, wb_reg} !== {1'b1, 32'h66, 5'd12}) begin
            n_fail++;
            $display("FAIL mis_wb: got wbv=%b data=%h reg=%0d required 1/00000066/12",
                     wb_valid, wb_data, wb_reg);
        end
        tick;
        $display("txn lw misaligned %h: aligned to %h", 32'h102, 32'h100);
`endif
    endtask

    initial begin
        test_reset;
        test_alu;
        test_lw_delayed;
        test_sw_same_cycle;
        test_timeout;
        test_reset_mid;
        test_back_to_back;
        test_ignored;
        test_misalign;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard bound on total run time.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
